fir_interp: RTL

Polyphase FIR lowpass interpolator by L. It is the upsampling counterpart of the team's polyphase decimating FIR, sitting on the DAC-bound path. Each accepted input sample produces L output samples, one per polyphase branch. A single time-multiplexed MAC evaluates each branch from a shared sample ring buffer and a phase-organised coefficient RAM.

---
 rtl/fir_interp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fir_interp.sv
// Polyphase FIR interpolator by L: each accepted sample yields L outputs, one per branch,
// computed by a single time-multiplexed MAC over a TPP-deep sample ring and banked coefficient RAM.
module fir_interp #(
  parameter int ORD         = 255,
  parameter int L           = 4,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       en,
  input  logic                                       din_valid,
  input  logic signed [SAMPLE_SIZE-1:0]              din,
  output logic signed [SAMPLE_SIZE+COEFF_SIZE-1:0]   dout,
  output logic                                       dout_valid,
  output logic                                       busy,
  output logic                                       overrun,
  input  logic                                       c_we,
  input  logic signed [COEFF_SIZE-1:0]               c_in,
  input  logic [$clog2(ORD+1)-1:0]                   c_addr
);

  localparam int TPP = (ORD + 1) / L;
  localparam int AW  = SAMPLE_SIZE + COEFF_SIZE;
  localparam int KW  = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int CW  = $clog2(TPP + 1);
  localparam int PW  = $clog2(L);

  if ((((ORD + 1) % L) != 0) || (L < 2)) begin : g_bad_cfg
    $error("fir_interp: ORD+1 must be a multiple of L, and L must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_n;

  logic signed [SAMPLE_SIZE-1:0] x_mem [TPP];
  logic signed [COEFF_SIZE-1:0]  coef  [L][TPP];

  logic [KW-1:0]                 wr_ptr, newest, rd_ptr;
  logic [CW-1:0]                 fill_cnt, k_cnt;
  logic [PW-1:0]                 phase;
  logic signed [SAMPLE_SIZE-1:0] x_rd;
  logic signed [COEFF_SIZE-1:0]  h_rd;
  logic                          rd_vld;
  logic signed [AW-1:0]          acc, prod;
  logic                          accept;

  assign accept = (state == IDLE) && din_valid && en && !c_we;
  assign prod   = AW'(x_rd) * AW'(h_rd);

  // h[c_addr] lives in bank c_addr % L at row c_addr / L, so branch p tap k is coef[p][k]
  always_ff @(posedge clk) begin
    if (c_we)
      coef[PW'(32'(c_addr) % L)][KW'(32'(c_addr) / L)] <= c_in;
  end

  always_ff @(posedge clk) begin
    if (accept)
      x_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = MAC;
      MAC: begin
        if (c_we)
          state_n = IDLE;
        else if (k_cnt == CW'(TPP))
          state_n = OUT;
      end
      OUT: begin
        if (c_we || (phase == PW'(L - 1)))
          state_n = IDLE;
        else
          state_n = MAC;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      newest     <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      k_cnt      <= '0;
      phase      <= '0;
      x_rd       <= '0;
      h_rd       <= '0;
      rd_vld     <= 1'b0;
      acc        <= '0;
    end else begin
      dout_valid <= 1'b0;
      rd_vld     <= 1'b0;
      busy       <= (state_n != IDLE);
      if (din_valid && en && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_ptr <= (wr_ptr == KW'(TPP - 1)) ? '0 : wr_ptr + 1'b1;
            newest <= wr_ptr;
            rd_ptr <= wr_ptr;
            if (fill_cnt != CW'(TPP))
              fill_cnt <= fill_cnt + 1'b1;
            phase <= '0;
            k_cnt <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          // Taps beyond the number of samples received since reset contribute zero
          if (k_cnt != CW'(TPP)) begin
            x_rd   <= (k_cnt < fill_cnt) ? x_mem[rd_ptr] : '0;
            h_rd   <= coef[phase][k_cnt[KW-1:0]];
            rd_vld <= 1'b1;
            rd_ptr <= (rd_ptr == '0) ? KW'(TPP - 1) : rd_ptr - 1'b1;
          end
          k_cnt <= k_cnt + 1'b1;
          if (rd_vld)
            acc <= acc + prod;
        end
        OUT: begin
          if (!c_we) begin
            dout       <= acc;
            dout_valid <= 1'b1;
            if (phase != PW'(L - 1)) begin
              phase  <= phase + 1'b1;
              acc    <= '0;
              k_cnt  <= '0;
              rd_ptr <= newest;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
